// File: rtl/tiny_project_mux_if.sv
// tiny_project_mux_if: Wishbone classic slave port bundle for tiny_project_mux.
interface tiny_project_mux_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    input  wbs_ack_o, wbs_dat_o
  );
  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/tiny_project_mux.sv
// tiny_project_mux: Wishbone-selected pad mux for N_PROJ tiny projects with guarded switchover.
// Define TINY_MUX_IO_SYNC_EN to insert a 2-flop synchronizer on the io_in path.
module tiny_project_mux #(
  parameter int          N_PROJ   = 4,
  parameter int          IO_W     = 38,
  parameter int          GUARD    = 4,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_ni,
  tiny_project_mux_if.slave        bus,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [N_PROJ*IO_W-1:0]   proj_io_in,
  input  logic [N_PROJ*IO_W-1:0]   proj_io_out,
  input  logic [N_PROJ*IO_W-1:0]   proj_io_oeb,
  output logic [N_PROJ-1:0]        proj_rst_n
);
  localparam int CW = GUARD > 1 ? $clog2(GUARD) : 1;
  localparam logic [1:0] IDLE = 2'd0, DRAIN = 2'd1, RELEASE = 2'd2, ACTIVE = 2'd3;
  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sel_q, sel_d, pend_sel_q, pend_sel_d, act_sel_q, act_sel_d;
  logic            en_q, en_d, err_q, err_d, ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            req, is_ctrl, is_stat, ctrl_wr, bad_wr, ok_wr, drain_done;
  logic [IO_W-1:0] io_in_s;
`ifdef TINY_MUX_IO_SYNC_EN
  logic [IO_W-1:0] sync1_q, sync2_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= io_in;
      sync2_q <= sync1_q;
    end
  assign io_in_s = sync2_q;
`else
  assign io_in_s = io_in;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      en_q       <= 1'b0;
      pend_sel_q <= '0;
      act_sel_q  <= '0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      pend_sel_q <= pend_sel_d;
      act_sel_q  <= act_sel_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  // A valid CTRL write always wins over the guard sequence, restarting or aborting it.
  always_comb begin
    req        = bus.wbs_cyc_i & bus.wbs_stb_i & ~ack_q;
    is_ctrl    = bus.wbs_adr_i == BASE_ADR;
    is_stat    = bus.wbs_adr_i == BASE_ADR + 32'h4;
    ctrl_wr    = req & bus.wbs_we_i & is_ctrl & bus.wbs_sel_i[3] & bus.wbs_sel_i[0];
    bad_wr     = ctrl_wr & bus.wbs_dat_i[31] & ({24'b0, bus.wbs_dat_i[7:0]} >= 32'(N_PROJ));
    ok_wr      = ctrl_wr & ~bad_wr;
    drain_done = state_q == DRAIN && cnt_q == CW'(GUARD - 1);
    ack_d      = req;
    dat_d      = (!req || bus.wbs_we_i) ? 32'h0 :
                 is_ctrl ? {en_q, 23'b0, sel_q} :
                 is_stat ? {15'b0, err_q, 6'b0, state_q, act_sel_q} : 32'h0;
    en_d       = ok_wr ? bus.wbs_dat_i[31] : en_q;
    sel_d      = ok_wr ? bus.wbs_dat_i[7:0] : sel_q;
    err_d      = bad_wr | (err_q & ~ok_wr);
    pend_sel_d = (ok_wr & bus.wbs_dat_i[31]) ? bus.wbs_dat_i[7:0] : pend_sel_q;
    state_d    = ok_wr ? (bus.wbs_dat_i[31] ? DRAIN : IDLE) :
                 drain_done ? RELEASE :
                 state_q == RELEASE ? ACTIVE : state_q;
    cnt_d      = (ok_wr || drain_done) ? '0 : state_q == DRAIN ? cnt_q + 1'b1 : cnt_q;
    act_sel_d  = (drain_done && !ok_wr) ? pend_sel_q : act_sel_q;
  end
  always_comb begin
    proj_rst_n = '0;
    io_out     = '0;
    io_oeb     = '1;
    proj_io_in = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (state_q == RELEASE && pend_sel_q == 8'(k)) proj_rst_n[k] = 1'b1;
      if (state_q == ACTIVE && act_sel_q == 8'(k)) begin
        proj_rst_n[k]                 = 1'b1;
        io_out                        = proj_io_out[k*IO_W +: IO_W];
        io_oeb                        = proj_io_oeb[k*IO_W +: IO_W];
        proj_io_in[k*IO_W +: IO_W]    = io_in_s;
      end
    end
  end
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;
endmodule

// File: tb/tb_tiny_project_mux.sv
// tb_tiny_project_mux: randomized scoreboard bench for tiny_project_mux against a time-based behavioural model.
module tb_tiny_project_mux;
  localparam int N = 4, W = 38, G = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef TINY_MUX_IO_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] io_in = '0, io_out, io_oeb;
  logic [N*W-1:0] proj_io_in, proj_io_out = '0, proj_io_oeb = '1;
  logic [N-1:0] proj_rst_n;
  tiny_project_mux_if bus();
  tiny_project_mux #(.N_PROJ(N), .IO_W(W), .GUARD(G), .BASE_ADR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .bus(bus), .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out), .proj_io_oeb(proj_io_oeb), .proj_rst_n(proj_rst_n));
  always #5 clk = ~clk;

  typedef struct {bit chk; logic [31:0] dat;} exp_t;
  exp_t sbq[$];
  int errors = 0, checks = 0, edges = 0, wr_edge = 0;
  bit m_en = 0, m_err = 0, rand_pads = 1;
  logic [7:0] m_sel = '0, m_prev = '0;
  logic [31:0] m_ctrl = '0;
  logic [W-1:0] h1 = '0, h2 = '0;

  always @(posedge clk) edges <= edges + 1;

  // Phase follows purely from the number of edges since the last accepted enable write.
  function automatic int phase();
    int d;
    d = edges - wr_edge;
    return !m_en ? 0 : d < G ? 1 : d == G ? 2 : 3;
  endfunction
  function automatic logic [7:0] act_sel();
    return (m_en && edges - wr_edge >= G) ? m_sel : m_prev;
  endfunction
  function automatic logic [31:0] status();
    return {15'b0, m_err, 6'b0, 2'(phase()), act_sel()};
  endfunction

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    logic [159:0] r;
    logic [63:0] s;
    #1;
    if (rand_pads) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      proj_io_out = r[N*W-1:0];
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      proj_io_oeb = r[N*W-1:0];
      s = {$urandom, $urandom};
      io_in = s[W-1:0];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int ph;
    logic [W-1:0] ein;
    logic [N-1:0] er;
    logic [N*W-1:0] epi;
    ein = LAT == 0 ? io_in : h2;
    h2 = rst_n ? h1 : '0;
    h1 = rst_n ? io_in : '0;
    ph = phase();
    er = (ph >= 2) ? (N'(1) << m_sel) : '0;
    epi = (ph == 3) ? ((N*W)'(ein) << (int'(m_sel) * W)) : '0;
    if (bus.wbs_ack_o) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ack: got ack=1 expected no outstanding request");
      end else begin
        e = sbq.pop_front();
        if (e.chk) check("rdata", bus.wbs_dat_o, e.dat);
      end
    end else check("dat_idle", bus.wbs_dat_o, 0);
    check("proj_rst_n", proj_rst_n, er);
    check("io_out", io_out, ph == 3 ? proj_io_out[int'(m_sel)*W +: W] : '0);
    check("io_oeb", io_oeb, ph == 3 ? proj_io_oeb[int'(m_sel)*W +: W] : {W{1'b1}});
    check("proj_io_in", proj_io_in, epi);
  end

  task automatic wb(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel, input bit we);
    exp_t e;
    int n;
    logic [7:0] pv;
    @(posedge clk);
    #1;
    pv = act_sel();
    e.chk = !we;
    e.dat = we ? 32'h0 : adr == BASE ? m_ctrl : adr == BASE + 32'h4 ? status() : 32'h0;
    sbq.push_back(e);
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = dat;
    bus.wbs_sel_i = sel;
    bus.wbs_we_i = we;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    @(posedge clk);
    #1;
    if (we && adr == BASE && sel[3] && sel[0]) begin
      if (dat[31] && dat[7:0] >= 8'(N)) m_err = 1;
      else begin
        m_prev = pv;
        m_err = 0;
        m_ctrl = dat & 32'h8000_00FF;
        m_en = dat[31];
        if (dat[31]) m_sel = dat[7:0];
        wr_edge = edges;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wbs_ack_o && n < 5);
    checks++;
    if (!bus.wbs_ack_o || n != 1) begin
      errors++;
      $display("FAIL ack_latency: got %0d cycles (ack=%b) expected 1", n, bus.wbs_ack_o);
    end
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
  endtask
  task automatic wr(input logic [31:0] dat);
    wb(BASE, dat, 4'hF, 1'b1);
  endtask
  task automatic rd(input logic [31:0] adr);
    wb(adr, 32'h0, 4'hF, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    m_en = 0;
    m_err = 0;
    m_prev = '0;
    m_ctrl = '0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    #1;
    check("async_oeb", io_oeb, {W{1'b1}});
    check("async_out", io_out, 0);
    check("async_rst", proj_rst_n, 0);
    check("async_pin", proj_io_in, 0);
    check("async_ack", bus.wbs_ack_o, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.wbs_sel_i = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(BASE + 32'h4);
    rd(BASE);
    rd(BASE + 32'h8);
    rand_pads = 0;
    wr(32'h8000_0002);
    repeat (8) @(posedge clk);
    #1;
    proj_io_out[2*W +: W] = 38'h15_5555_5555;
    proj_io_oeb[2*W +: W] = '0;
    io_in = 38'h2A;
    repeat (3) @(negedge clk);
    check("dir_out", io_out, 38'h15_5555_5555);
    check("dir_oeb", io_oeb, 0);
    check("dir_pin", proj_io_in, (N*W)'(38'h2A) << (2 * W));
    check("dir_rst", proj_rst_n, 4'b0100);
    rand_pads = 1;
    wr(32'h8000_0001);
    wr(32'h8000_0003);
    repeat (10) @(posedge clk);
    rd(BASE + 32'h4);
    wr(32'h8000_0007);
    rd(BASE + 32'h4);
    wb(BASE, 32'h8000_0001, 4'b0111, 1'b1);
    rd(BASE);
    wr(32'h8000_0000);
    rd(BASE + 32'h4);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] adr, dat;
      logic [3:0] sel;
      int a;
      a = $urandom_range(0, 3);
      adr = a == 0 ? BASE : a == 1 ? BASE + 32'h4 : a == 2 ? BASE + 32'h8 : $urandom;
      dat = {1'($urandom_range(0, 1)), 23'($urandom), 8'($urandom_range(0, 5))};
      sel = $urandom_range(0, 1) ? 4'hF : 4'($urandom);
      wb(adr, dat, sel, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 8)) @(posedge clk);
    end
    wr(32'h8000_0003);
    repeat (8) @(posedge clk);
    wr(32'h0000_0000);
    rd(BASE + 32'h4);
    wr(32'h8000_0001);
    do_reset();
    rd(BASE + 32'h4);
    rd(BASE);
    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
